serial_subtractor_32bit: RTL and testbench
==========================================

# serial_subtractor_32bit

Multi-cycle digit-serial subtractor. Computes `diff = A - B - bin` and the borrow-out over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle, LSB digit first. It is the inverse-operation companion to the combinational 32-bit full adder and sits behind a valid/ready handshake on both the operand and result sides. Its small ripple stage trades latency for area.

## Interface
- `WIDTH`, default 32: operand and result width; must be a multiple of DIGIT.
- `DIGIT`, default 4: bits subtracted per cycle; legal values are 1, 2, 4, 8, 16 and 32.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands `a`, `b`, `bin` are valid.
- `in_ready`, output, 1: block can accept operands; high only in IDLE.
- `a`, input, WIDTH: minuend.
- `b`, input, WIDTH: subtrahend.
- `bin`, input, 1: borrow-in.
- `out_valid`, output, 1: result is valid; high only in DONE.
- `out_ready`, input, 1: consumer accepts the result.
- `diff`, output, WIDTH: (a - b - bin) mod 2^WIDTH.
- `bout`, output, 1: unsigned borrow-out; 1 iff a < b + bin.
- `overflow`, output, 1: two's-complement overflow (see Configuration).

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE**:
  - `in_ready` = 1.
  - On `in_valid && in_ready` at an edge: latch `a`, `b`, `bin` into operand shift registers, load the internal borrow with `bin`, clear the digit counter, and go to RUN.
- **RUN**:
  - Each cycle, subtract the current low DIGIT bits of A and B with the internal borrow.
  - Shift the DIGIT result bits into the MSB end of the result register and update the internal borrow.
  - Increment the counter.
  - After the cycle processing digit WIDTH/DIGIT-1, go to DONE.
  - Input changes during RUN are ignored.
- **DONE**:
  - `out_valid` = 1.
  - `diff`, `bout` and `overflow` are held stable until `out_valid && out_ready`.
  - On that handshake, go to IDLE.
- Arithmetic:
  - `diff` is the exact low WIDTH bits of a - b - bin.
  - `bout` is the final internal borrow.
  - No sign extension and no saturation.
- Boundary cases:
  - a == b with bin = 0 gives `diff` = 0, `bout` = 0.
  - a == b with bin = 1 gives `diff` all ones, `bout` = 1.
  - a = 0 with b = all ones gives `diff` = 1, `bout` = 1.
- `diff`, `bout` and `overflow` keep their DONE values after leaving DONE. They are only valid while `out_valid` = 1.

## Timing
- Reset (`rst` = 1 at an edge):
  - State goes to IDLE.
  - `in_ready` = 1 and `out_valid` = 0 from the following cycle.
  - `diff` = 0, `bout` = 0, `overflow` = 0.
  - Counter and operand registers are cleared.
- Reset mid-operation, in RUN or DONE, abandons the operation with no result output. It has priority over any simultaneous handshake.
- Latency:
  - Operands accepted at edge k give `out_valid` = 1 after edge k + WIDTH/DIGIT.
  - That is 8 cycles at the defaults; with DIGIT = WIDTH it is 1 cycle.
- Throughput:
  - At most one operation per WIDTH/DIGIT + 2 cycles (accept, RUN cycles, DONE, return to IDLE).
  - `in_ready` is low from the edge after acceptance until the edge after the result handshake. There is no overlap between operations.
- `in_ready` and `out_valid` are pure functions of state; neither depends combinationally on `in_valid` or `out_ready`.
- `out_ready` = 1 on the first DONE cycle gives a 1-cycle DONE.
- Backpressure of any length holds DONE with stable outputs.

## Configuration
- Macro `SERIAL_SUB_OVERFLOW_EN` controls the overflow logic.
- Defined:
  - `overflow` is registered with the result.
  - `overflow` = 1 iff the signed value a - b - bin lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - It is computed as borrow into MSB XOR borrow out of MSB during the final digit.
- Not defined:
  - `overflow` is tied to 0.
  - The MSB-borrow capture logic is not built.
  - All other behaviour is identical.

## Test plan
- Basic subtraction, defaults: a = 0x00000005, b = 0x00000001, bin = 0 → after 8 cycles `diff` = 0x00000004, `bout` = 0, `overflow` = 0.
- Unsigned wrap-around: a = 0x00000000, b = 0x00000001, bin = 0 → `diff` = 0xFFFFFFFF, `bout` = 1; with the macro defined, `overflow` = 0.
- Signed overflow, macro defined:
  - a = 0x80000000, b = 0x00000001, bin = 0 → `diff` = 0x7FFFFFFF, `bout` = 0, `overflow` = 1.
  - a = 0x7FFFFFFF, b = 0xFFFFFFFF, bin = 0 → `diff` = 0x80000000, `bout` = 1, `overflow` = 1.
- Borrow-in chain: a = 0x12345678, b = 0x12345678, bin = 1 → `diff` = 0xFFFFFFFF, `bout` = 1; repeat with DIGIT = 1 and DIGIT = 32 and check latency of 32 and 1 cycles.
- Backpressure:
  - Hold `out_ready` = 0 for 5 cycles in DONE → `diff`, `bout` and `out_valid` stay stable and `in_ready` stays 0.
  - Raise `out_ready` → `in_ready` = 1 on the next cycle.
  - A new operand presented during DONE is not accepted.
- Reset mid-operation: assert `rst` for 1 cycle at RUN cycle 3 → next cycle `in_ready` = 1, `out_valid` = 0, `diff` = 0; a following 0xA - 0x3 completes normally with `diff` = 0x00000007.

Source files
------------

// File: rtl/serial_subtractor_32bit.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH/DIGIT cycles, LSB digit first.
// Valid/ready handshake on both the operand and the result side; one operation in flight.
// Optional signed-overflow output is built when SERIAL_SUB_OVERFLOW_EN is defined,
// otherwise overflow is tied to 0.
module serial_subtractor_32bit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int unsigned NumDigits = WIDTH / DIGIT;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic [WIDTH-1:0]  res_d;
    logic [CntW-1:0]   cnt_q;
    logic              borrow_q;
    logic              bout_q;

    logic [DIGIT:0]    step;
    logic [DIGIT-1:0]  dig_diff;
    logic              dig_bout;
    logic              last_digit;

    // One digit of ripple subtraction; the extra top bit of step is the borrow out.
    always_comb begin
        step       = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow_q};
        dig_diff   = step[DIGIT-1:0];
        dig_bout   = step[DIGIT];
        last_digit = (cnt_q == CntW'(NumDigits - 1));
        // New digit enters at the MSB end so the LSB digit ends up at bit 0.
        res_d      = (res_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ovf_q;
    logic ovf_d;

    // Borrow into the MSB is recovered from the MSB sum bit: d = a ^ b ^ borrow_in.
    always_comb begin
        ovf_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_diff[DIGIT-1] ^ dig_bout;
    end

    // Overflow flag captured with the final digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StRun && last_digit) begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    // Control FSM, operand/result shift registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= bin;
                        cnt_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                    end
                end
                StRun: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    res_q    <= res_d;
                    borrow_q <= dig_bout;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (last_digit) begin
                        bout_q      <= dig_bout;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = res_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Self-checking bench for serial_subtractor_32bit: default instance (DIGIT=4) plus
// DIGIT=1 and DIGIT=32 instances for latency checks. Honours SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor_32bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a, b;
    logic        bin;

    logic        in_valid, out_ready, in_ready, out_valid, bout, overflow;
    logic [31:0] diff;
    logic        iv1, or1, ir1, ov1, bo1, of1;
    logic [31:0] d1;
    logic        iv32, or32, ir32, ov32, bo32, of32;
    logic [31:0] d32;

    serial_subtractor_32bit #(.WIDTH(32), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .bin(bin), .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout),
        .overflow(overflow)
    );

    serial_subtractor_32bit #(.WIDTH(32), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .bin(bin), .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1),
        .overflow(of1)
    );

    serial_subtractor_32bit #(.WIDTH(32), .DIGIT(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
        .bin(bin), .out_valid(ov32), .out_ready(or32), .diff(d32), .bout(bo32),
        .overflow(of32)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference: unsigned 33-bit difference and exact signed 34-bit difference.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [32:0]        u;
        logic signed [33:0] s;
        exp_t               e;
        u    = {1'b0, x} - {1'b0, y} - {32'b0, bi};
        s    = $signed({{2{x[31]}}, x}) - $signed({{2{y[31]}}, y}) - $signed({33'b0, bi});
        e.d  = u[31:0];
        e.bo = u[32];
`ifdef SERIAL_SUB_OVERFLOW_EN
        e.ov = (s > 34'sd2147483647) || (s < -34'sd2147483648);
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    // Present one operand set to the default instance (assumed idle) for one edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic bi);
        a = x; b = y; bin = bi; in_valid = 1'b1;
        sb.push_back(model(x, y, bi));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; iv1 = 1'b0; or1 = 1'b0;
        iv32 = 1'b0; or32 = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hs: got in_ready/out_valid %b expected 10", {in_ready, out_valid});
        end
        checks++;
        if ({diff, bout, overflow} !== 34'h0) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0", {diff, bout, overflow});
        end
        checks++;
        if ({ir1, ov1, ir32, ov32} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_variants: got %b expected 1010", {ir1, ov1, ir32, ov32});
        end
    endtask

    task automatic test_arith;
        logic [64:0] tbl [0:9];
        exp_t        e;
        int          cyc;
        tbl[0] = {32'h00000005, 32'h00000001, 1'b0};
        tbl[1] = {32'h00000000, 32'h00000001, 1'b0};
        tbl[2] = {32'h80000000, 32'h00000001, 1'b0};
        tbl[3] = {32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[4] = {32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[5] = {32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        tbl[6] = {32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[7] = {32'h12345678, 32'h12345678, 1'b1};
        tbl[8] = {$urandom(), $urandom(), 1'b1};
        tbl[9] = {$urandom(), $urandom(), 1'b0};
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i][64:33], tbl[i][32:1], tbl[i][0]);
            wait_valid(cyc);
            checks++;
            if (cyc !== 8) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d cycles expected 8", i, cyc);
            end
            e = sb.pop_front();
            checks++;
            if ({diff, bout, overflow} !== e) begin
                errors++;
                $display("FAIL result[%0d]: got diff=%h bout=%b ovf=%b expected diff=%h bout=%b ovf=%b",
                         i, diff, bout, overflow, e.d, e.bo, e.ov);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL release[%0d]: got in_ready/out_valid %b expected 10", i,
                         {in_ready, out_valid});
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        int   t_prev;
        int   t_acc;
        out_ready = 1'b1;
        t_prev    = -1;
        for (int i = 0; i < 4; i++) begin
            t_acc = cyc_cnt;
            issue($urandom(), $urandom(), 1'($urandom_range(0, 1)));
            if (t_prev >= 0) begin
                checks++;
                if (t_acc - t_prev !== 10) begin
                    errors++;
                    $display("FAIL period[%0d]: got %0d cycles expected 10", i, t_acc - t_prev);
                end
            end
            t_prev = t_acc;
            wait_valid(cyc);
            e = sb.pop_front();
            checks++;
            if ({diff, bout, overflow} !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, {diff, bout, overflow}, e);
            end
            @(posedge clk); #1;
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_done1[%0d]: got %b expected 10", i, {in_ready, out_valid});
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   cyc;
        int   seen;
        issue(32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
        wait_valid(cyc);
        e = sb[0];
        // Competing operand held during DONE must not be taken.
        a = 32'h11111111; b = 32'h22222222; bin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, diff, bout, overflow} !== {2'b10, e}) begin
                errors++;
                $display("FAIL hold[%0d]: got %h expected %h", i,
                         {out_valid, in_ready, diff, bout, overflow}, {2'b10, e});
            end
        end
        void'(sb.pop_front());
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: got %b expected 10", {in_ready, out_valid});
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL bp_no_accept: got %0d busy cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   cyc;
        issue(32'h89ABCDEF, 32'h01234567, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        checks++;
        if ({in_ready, out_valid, diff} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset: got %h expected %h", {in_ready, out_valid, diff},
                     {2'b10, 32'h0});
        end
        issue(32'h0000000A, 32'h00000003, 1'b0);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++;
        if ({cyc, diff, bout} !== {32'd8, 32'h00000007, 1'b0} || overflow !== e.ov) begin
            errors++;
            $display("FAIL after_reset: got cyc=%0d diff=%h bout=%b expected cyc=8 diff=00000007 bout=0",
                     cyc, diff, bout);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_digit_variants;
        exp_t e;
        int   cyc;
        a = 32'h12345678; b = 32'h12345678; bin = 1'b1;
        // DIGIT = 1
        sb.push_back(model(a, b, bin));
        iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        cyc = 0;
        while (ov1 !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if ({cyc, d1, bo1, of1} !== {32'd32, e}) begin
            errors++;
            $display("FAIL digit1: got cyc=%0d res=%h expected cyc=32 res=%h", cyc,
                     {d1, bo1, of1}, e);
        end
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        checks++;
        if ({ir1, ov1} !== 2'b10) begin
            errors++;
            $display("FAIL digit1_release: got %b expected 10", {ir1, ov1});
        end
        // DIGIT = 32
        sb.push_back(model(a, b, bin));
        iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        cyc = 0;
        while (ov32 !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if ({cyc, d32, bo32, of32} !== {32'd1, e}) begin
            errors++;
            $display("FAIL digit32: got cyc=%0d res=%h expected cyc=1 res=%h", cyc,
                     {d32, bo32, of32}, e);
        end
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        checks++;
        if ({ir32, ov32} !== 2'b10) begin
            errors++;
            $display("FAIL digit32_release: got %b expected 10", {ir32, ov32});
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_digit_variants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
